// File: rtl/micro_sequencer_pkg.sv
// rtl/micro_sequencer_pkg.sv - shared phase encodings, widths and opcodes for the micro-sequencer
package micro_sequencer_pkg;

  localparam int CPU_STATES         = 4;
  localparam int CPU_STATE_WIDTH    = $clog2(CPU_STATES);
  localparam int MBRANCH_ADDR_WIDTH = 10;
  localparam int UINSTR_WIDTH       = 44;
  localparam int RETIRED_WIDTH      = 16;
  localparam int UOP_MSB            = UINSTR_WIDTH - 1;
  localparam int UOP_LSB            = UINSTR_WIDTH - 3;

  localparam logic [2:0] UOP_HALT = 3'b111;

  typedef enum logic [CPU_STATE_WIDTH-1:0] {
    FETCH    = 2'd0,
    DECODE   = 2'd1,
    EXECUTE1 = 2'd2,
    EXECUTE2 = 2'd3
  } cpu_state_e;

  function automatic logic [2:0] uop_of(input logic [UINSTR_WIDTH-1:0] word);
    return word[UOP_MSB:UOP_LSB];
  endfunction

  function automatic logic [RETIRED_WIDTH-1:0] sat_inc(input logic [RETIRED_WIDTH-1:0] cnt);
    return (cnt == {RETIRED_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - four-phase micro-program sequencer with branch, halt and retire count
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          run,
  input  logic [UINSTR_WIDTH-1:0]       urom_data,
  input  logic                          is_branch,
  input  logic [MBRANCH_ADDR_WIDTH-1:0] mbranch_target,
  input  logic                          branch_cond,
  output logic [MBRANCH_ADDR_WIDTH-1:0] urom_addr,
  output logic                          urom_rd_en,
  output logic [UINSTR_WIDTH-1:0]       uinstr,
  output logic [CPU_STATE_WIDTH-1:0]    cpu_state,
  output logic [MBRANCH_ADDR_WIDTH-1:0] upc,
  output logic                          halted,
  output logic [RETIRED_WIDTH-1:0]      retired
);

  cpu_state_e                    state_q, state_d;
  logic [MBRANCH_ADDR_WIDTH-1:0] upc_q, upc_d;
  logic [UINSTR_WIDTH-1:0]       uinstr_q, uinstr_d;
  logic                          halted_q, halted_d;
  logic [RETIRED_WIDTH-1:0]      retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    uinstr_d  = uinstr_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (run && !halted_q) state_d = DECODE;
      end
      DECODE: begin
        uinstr_d = urom_data;
        state_d  = EXECUTE1;
      end
      EXECUTE1: begin
        state_d = EXECUTE2;
      end
      EXECUTE2: begin
        // Branch inputs are only trusted here; the decode register is stable by now.
        upc_d     = (is_branch && branch_cond) ? mbranch_target : upc_q + 1'b1;
        retired_d = sat_inc(retired_q);
        if (uop_of(uinstr_q) == UOP_HALT) halted_d = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= FETCH;
      upc_q     <= '0;
      uinstr_q  <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      uinstr_q  <= uinstr_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // The read strobe depends on run directly so a fetch is issued in the same FETCH cycle.
  assign urom_rd_en = (state_q == FETCH) && run && !halted_q;
  assign urom_addr  = upc_q;
  assign uinstr     = uinstr_q;
  assign cpu_state  = state_q;
  assign upc        = upc_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports sys_clk and sys_reset.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- sys_clk  in  1  system clock.
- sys_reset  in  1  asynchronous active-high reset.
- run  in  1  permits leaving FETCH; sampled only in FETCH.
- urom_data  in  44  micro-instruction from micro-ROM; valid one cycle after urom_rd_en.
- is_branch  in  1  registered branch flag from the micro-decode register.
- mbranch_target  in  MBRANCH_ADDR_WIDTH (10)  registered branch target.
- branch_cond  in  1  branch condition from the ALU.
- urom_addr  out  10  micro-ROM address.
- urom_rd_en  out  1  micro-ROM read strobe.
- uinstr  out  44  latched micro-instruction that feeds the decoder.
- cpu_state  out  clog2(CPU_STATES) (2)  current phase.
- upc  out  10  micro-program counter.
- halted  out  1  sticky halt indication.
- retired  out  16  saturating count of retired micro-instructions.

Function
REQ-003 cpu_state SHALL cycle FETCH -> DECODE -> EXECUTE1 -> EXECUTE2 -> FETCH, using the shared FETCH, DECODE, EXECUTE1 and EXECUTE2 encodings.
REQ-004 FETCH behaviour:
- When run=1 and halted=0: urom_rd_en=1 and urom_addr=upc for that cycle, and the next state is DECODE.
- Otherwise: urom_rd_en=0, and the block stays in FETCH.
REQ-005 urom_rd_en SHALL be 0 in every state other than FETCH.
REQ-006 In DECODE, uinstr SHALL capture urom_data on the clock edge leaving DECODE; uinstr SHALL hold its value in all other states.
REQ-007 EXECUTE1 SHALL last exactly one cycle, with no sequencer side effects.
REQ-008 At the edge leaving EXECUTE2, the next upc SHALL be:
- mbranch_target when is_branch=1 and branch_cond=1;
- otherwise upc+1 modulo 1024, so 1023 wraps to 0.
REQ-009 is_branch, branch_cond and mbranch_target SHALL be sampled only in EXECUTE2; their values in other states SHALL be ignored.
REQ-010 If uinstr[43:41] equals UOP_HALT at the EXECUTE2 exit:
- halted SHALL be set to 1;
- upc SHALL still advance per REQ-008;
- the state SHALL return to FETCH.
REQ-011 halted SHALL remain 1 until reset; while halted=1, the block SHALL idle in FETCH with urom_rd_en=0 regardless of run.
REQ-012 retired SHALL increment by 1 at each EXECUTE2 exit, including the HALT micro-instruction, and SHALL saturate at 16'hFFFF.
REQ-013 Deasserting run outside FETCH SHALL NOT abort the current micro-instruction; the instruction completes and the block then holds in FETCH.
REQ-014 Total latency SHALL be four cycles per micro-instruction when run=1, with no bubbles between instructions.
REQ-015 All outputs SHALL be registered, except urom_rd_en and urom_addr, which are decoded from cpu_state and upc.

Reset
REQ-016 Asserting sys_reset SHALL immediately force the following values, independent of sys_clk:
- cpu_state=FETCH, upc=0, uinstr=0, halted=0, retired=0.
REQ-017 Reset asserted mid-instruction SHALL discard that instruction; it SHALL NOT be counted in retired and SHALL NOT update upc.
REQ-018 After reset deasserts, the first fetch SHALL occur in the first FETCH cycle in which run=1.

Structure
REQ-019 The shared defines file SHALL hold the following, and the block SHALL NOT redefine them locally:
- CPU_STATES and the FETCH, DECODE, EXECUTE1 and EXECUTE2 encodings;
- MBRANCH_ADDR_WIDTH;
- UINSTR_WIDTH (44);
- UOP_HALT (3'b111);
- RETIRED_WIDTH (16).
REQ-020 The block SHALL be a single module with no sub-modules; the state register, upc, retire counter and halt flag SHALL reside in it.

Verification
REQ-021 Reset, then run=1, with ROM holding non-branch words at addresses 0..3 -> urom_addr sequence 0,1,2,3 on FETCH cycles spaced 4 cycles apart; retired=4 after 16 cycles.
REQ-022 Branch taken: in EXECUTE2 of the instruction at upc=5, drive is_branch=1, branch_cond=1, mbranch_target=10'h200 -> next urom_addr=0x200.
REQ-023 Branch not taken: same stimulus as REQ-022 but branch_cond=0 -> next urom_addr=6.
REQ-024 Wrap-around: a non-branch instruction at upc=1023 -> next upc=0.
REQ-025 HALT: urom_data[43:41]=3'b111 at upc=7 -> halted=1, upc=8, retired incremented, and urom_rd_en stays 0 for 20 further cycles with run=1.
REQ-026 Reset mid-operation: assert sys_reset asynchronously in EXECUTE1 with retired=3 -> all outputs read reset values before the next clock edge; retired=0.
